// File: rtl/input_confirm_responder_pkg.sv
// Shared state encoding and default sizing for the switch-input responder.
// Latency: n/a (declarations only). Backpressure: n/a.
package input_confirm_responder_pkg;

   localparam int STATE_W         = 3;
   localparam int IO_WIDTH_DEF    = 16;
   localparam int DATA_WIDTH_DEF  = 32;
   localparam int BLINK_DIV_DEF   = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE       = 3'd0,
      ST_ARMED      = 3'd1,
      ST_WAIT_PRESS = 3'd2,
      ST_CAPTURE    = 3'd3,
      ST_DONE       = 3'd4
   } state_t;

   function automatic logic is_waiting(state_t s);
      return (s == ST_ARMED) || (s == ST_WAIT_PRESS);
   endfunction

endpackage

// File: rtl/input_confirm_responder_if.sv
// Core/operator side bundle: request, button, switches in; data, strobe, stall, LED out.
// Latency: n/a. Backpressure: stall is the only hold signal toward the core.
interface input_confirm_responder_if #(
   parameter int IO_WIDTH   = 16,
   parameter int DATA_WIDTH = 32
);
   logic                  is_input;
   logic                  confirmation;
   logic [IO_WIDTH:0]     sw;
   logic [DATA_WIDTH-1:0] input_data;
   logic                  input_valid;
   logic                  stall;
   logic                  wait_led;

   modport master (
      output is_input, confirmation, sw,
      input  input_data, input_valid, stall, wait_led
   );

   modport slave (
      input  is_input, confirmation, sw,
      output input_data, input_valid, stall, wait_led
   );
endinterface

// File: rtl/input_confirm_responder_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level plus a one-cycle rising-edge pulse.
// Latency: 2 cycles to sync_q, rise coincident with sync_q rising. Backpressure: none.
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_q,
   output logic rise
);
   logic meta_q;
   logic level_q;
   logic level_d1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q     <= 1'b0;
         level_q    <= 1'b0;
         level_d1_q <= 1'b0;
      end else begin
         meta_q     <= async_in;
         level_q    <= meta_q;
         level_d1_q <= level_q;
      end
   end

   assign sync_q = level_q;
   assign rise   = level_q & ~level_d1_q;
endmodule

// File: rtl/input_confirm_responder.sv
// Stalls the core on an input request until a fresh confirmation press, then captures and extends the switches.
// Latency: synced press edge -> input_valid 2 cycles. Backpressure: stall holds the core for the whole wait.
module input_confirm_responder
   import input_confirm_responder_pkg::*;
#(
   parameter int IO_WIDTH   = IO_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BLINK_DIV  = BLINK_DIV_DEF
) (
   input  logic                    slow_clock,
   input  logic                    reset,
   input_confirm_responder_if.slave io
);
   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   state_t                state_q, state_d;
   logic                  sync_q, press;
   logic [CNT_W-1:0]      blink_cnt_q;
   logic                  led_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] ext_w;
   logic                  stall_c, valid_c, waiting;

   sync_edge_detect u_sync (
      .clk      (slow_clock),
      .rst_n    (reset),
      .async_in (io.confirmation),
      .sync_q   (sync_q),
      .rise     (press)
   );

   assign waiting = is_waiting(state_q);
   assign ext_w   = {{(DATA_WIDTH-IO_WIDTH){io.sw[IO_WIDTH] & io.sw[IO_WIDTH-1]}},
                     io.sw[IO_WIDTH-1:0]};

   always_ff @(posedge slow_clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         blink_cnt_q <= '0;
         led_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_CAPTURE) data_q <= ext_w;
         if (waiting) begin
            if (blink_cnt_q == CNT_W'(BLINK_DIV-1)) begin
               blink_cnt_q <= '0;
               led_q       <= ~led_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + 1'b1;
            end
         end else begin
            blink_cnt_q <= '0;
            led_q       <= 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      stall_c = 1'b0;
      valid_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Stall follows the request combinationally so the core cannot run past it.
            stall_c = io.is_input & reset;
            if (io.is_input) state_d = sync_q ? ST_ARMED : ST_WAIT_PRESS;
         end
         ST_ARMED: begin
            stall_c = 1'b1;
            if (!io.is_input)  state_d = ST_IDLE;
            else if (!sync_q)  state_d = ST_WAIT_PRESS;
         end
         ST_WAIT_PRESS: begin
            stall_c = 1'b1;
            if (!io.is_input)  state_d = ST_IDLE;
            else if (press)    state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            stall_c = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            valid_c = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign io.stall       = stall_c;
   assign io.input_valid = valid_c;
   assign io.input_data  = data_q;
   assign io.wait_led    = led_q & waiting;
endmodule

// File: tb/tb_input_confirm_responder.sv
// Randomized + directed bench for input_confirm_responder against a cycle-level behavioural model.
module tb_input_confirm_responder;
   localparam int BLINK = 8;

   logic clk;
   logic rst_n;

   input_confirm_responder_if #(.IO_WIDTH(16), .DATA_WIDTH(32)) bus ();

   input_confirm_responder #(.IO_WIDTH(16), .DATA_WIDTH(32), .BLINK_DIV(BLINK)) dut (
      .slow_clock (clk),
      .reset      (rst_n),
      .io         (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests = 0;
   int fails = 0;

   // Model: request bookkeeping in plain flags/counters
   bit          m_wait, m_need_release, m_cap, m_done;
   int          m_wc;
   bit          s1, s2, s2p;
   logic [31:0] m_data;

   logic [31:0] obs_data;
   logic        obs_valid, obs_stall, obs_led;
   int          nstrobe = 0;
   logic [31:0] last_data;

   function automatic logic [31:0] extend(input logic [16:0] s);
      int v;
      v = int'(s[15:0]);
      if (s[16] && v >= 32768) v = v - 65536;
      return 32'(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         if (fails <= 30) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wait = 0; m_need_release = 0; m_cap = 0; m_done = 0; m_wc = 0;
      s1 = 0; s2 = 0; s2p = 0; m_data = '0;
   endtask

   task automatic model_clock(input bit ii, input bit c, input logic [16:0] s);
      bit press;
      press = s2 && !s2p;
      if (m_done) begin
         m_done = 0;
      end else if (m_cap) begin
         m_data = extend(s);
         m_cap  = 0;
         m_done = 1;
      end else if (m_wait) begin
         m_wc++;
         if (!ii) m_wait = 0;
         else if (m_need_release) begin
            if (!s2) m_need_release = 0;
         end else if (press) begin
            m_wait = 0;
            m_cap  = 1;
         end
      end else if (ii) begin
         m_wait = 1;
         m_need_release = s2;
         m_wc = 0;
      end
      s2p = s2; s2 = s1; s1 = c;
   endtask

   task automatic step(input bit r, input bit ii, input bit c, input logic [16:0] s);
      bit exp_stall, exp_led;
      @(negedge clk);
      rst_n = r; bus.is_input = ii; bus.confirmation = c; bus.sw = s;
      if (!r) model_reset();
      #1;
      exp_stall = m_wait || m_cap || (!m_done && ii && r);
      exp_led   = m_wait && (((m_wc / BLINK) % 2) == 1);
      chk("stall", 32'(bus.stall), 32'(exp_stall));
      chk("input_valid", 32'(bus.input_valid), 32'(m_done));
      chk("input_data", bus.input_data, m_data);
      chk("wait_led", 32'(bus.wait_led), 32'(exp_led));
      obs_stall = bus.stall; obs_valid = bus.input_valid;
      obs_data = bus.input_data; obs_led = bus.wait_led;
      if (bus.input_valid) begin
         nstrobe++;
         last_data = bus.input_data;
      end
      @(posedge clk);
      if (r) model_clock(ii, c, s);
   endtask

   task automatic transfer(input logic [16:0] s, input logic [31:0] lit, input bit drop, input string name);
      int n0;
      n0 = nstrobe;
      step(1, 1, 0, s);
      step(1, 1, 0, s);
      repeat (3) step(1, 1, 1, s);
      for (int i = 0; i < 20 && nstrobe == n0; i++) step(1, 1, 0, s);
      chk({name, "_strobes"}, 32'(nstrobe - n0), 32'd1);
      chk({name, "_data"}, last_data, lit);
      if (drop) step(1, 0, 0, s);
   endtask

   logic [31:0] led_log [0:23];
   bit          ii_r, c_r;

   initial begin
      int n0;
      rst_n = 1'b0; bus.is_input = 1'b0; bus.confirmation = 1'b0; bus.sw = '0;
      model_reset();

      repeat (3) step(0, 0, 0, 17'h0);
      chk("reset_stall", 32'(obs_stall), 32'd0);
      chk("reset_data", obs_data, 32'd0);
      step(1, 0, 0, 17'h0);

      transfer(17'h0_00A5, 32'h0000_00A5, 1, "basic");
      chk("basic_stall_after", 32'(obs_stall), 32'd0);
      transfer(17'h1_8001, 32'hFFFF_8001, 1, "sign_neg");
      transfer(17'h0_8001, 32'h0000_8001, 1, "zero_ext");
      transfer(17'h1_7FFF, 32'h0000_7FFF, 1, "sign_pos");

      // Stale press: button held before the request
      repeat (4) step(1, 0, 1, 17'h0_0033);
      n0 = nstrobe;
      for (int j = 0; j < 24; j++) begin
         step(1, 1, 1, 17'h0_0033);
         led_log[j] = 32'(obs_led);
      end
      chk("stale_no_capture", 32'(nstrobe - n0), 32'd0);
      chk("led_k7", led_log[8], 32'd0);
      chk("led_k8", led_log[9], 32'd1);
      chk("led_k15", led_log[16], 32'd1);
      chk("led_k16", led_log[17], 32'd0);
      transfer(17'h0_0033, 32'h0000_0033, 1, "after_release");

      // Abort while waiting
      n0 = nstrobe;
      repeat (5) step(1, 1, 0, 17'h0_0777);
      repeat (3) step(1, 0, 0, 17'h0_0777);
      chk("abort_no_strobe", 32'(nstrobe - n0), 32'd0);
      chk("abort_data_kept", obs_data, 32'h0000_0033);
      chk("abort_stall", 32'(obs_stall), 32'd0);

      // Back-to-back with is_input held across both
      transfer(17'h0_1234, 32'h0000_1234, 0, "b2b_first");
      transfer(17'h0_5678, 32'h0000_5678, 1, "b2b_second");

      // Reset mid WAIT_PRESS
      repeat (12) step(1, 1, 0, 17'h0_0042);
      step(0, 1, 0, 17'h0_0042);
      chk("midreset_stall", 32'(obs_stall), 32'd0);
      chk("midreset_valid", 32'(obs_valid), 32'd0);
      chk("midreset_data", obs_data, 32'd0);
      chk("midreset_led", 32'(obs_led), 32'd0);
      step(1, 0, 0, 17'h0);

      ii_r = 0; c_r = 0;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 11) == 0) ii_r = ~ii_r;
         if ($urandom_range(0, 3) == 0) c_r = ~c_r;
         step(($urandom_range(0, 599) != 0), ii_r, c_r, 17'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
